// File: rtl/adder64_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder64_issue_ctrl_pkg
//  Description : Shared constants and types for the adder64 issue front-end.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder64_issue_ctrl_pkg;

    localparam int c_LEN_DATA    = 64;   // operand/result width
    localparam int c_ADD_LATENCY = 9;    // adder64 valid-to-rdy latency
    localparam int c_ADD_LANES   = 8;    // byte lanes of the SIMD adder
    localparam int c_TAG_W       = 5;    // default request tag width
    localparam int c_DEPTH       = 16;   // default result buffer depth

    typedef logic [c_ADD_LANES-1:0] lane_vec_t;

    // Result FIFO entry is {tag, sum, cout}
    function automatic int res_entry_width(input int tag_w, input int len_data);
        return tag_w + len_data + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder64_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder64_issue_ctrl_if
//  Description : Request, adder-side and response signals of the issue
//                controller. 'slave' is the controller view, 'master' the
//                surrounding dispatch/adder/writeback view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adder64_issue_ctrl_if
    import adder64_issue_ctrl_pkg::*;
#(
    parameter int LEN_DATA = c_LEN_DATA,
    parameter int TAG_W    = c_TAG_W
);
    logic                req_valid;
    logic                req_ready;
    logic [LEN_DATA-1:0] req_a;
    logic [LEN_DATA-1:0] req_b;
    lane_vec_t           req_cin;
    lane_vec_t           req_cmsk_n;
    logic [TAG_W-1:0]    req_tag;

    logic                exe_valid;
    logic [LEN_DATA-1:0] exe_a;
    logic [LEN_DATA-1:0] exe_b;
    lane_vec_t           exe_cin;
    lane_vec_t           exe_cmsk_n;
    logic                exe_rdy;
    logic [LEN_DATA-1:0] exe_sum;
    logic                exe_cout;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [LEN_DATA-1:0] rsp_sum;
    logic                rsp_cout;
    logic [TAG_W-1:0]    rsp_tag;
    logic                err;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_cmsk_n, req_tag,
        output req_ready,
        output exe_valid, exe_a, exe_b, exe_cin, exe_cmsk_n,
        input  exe_rdy, exe_sum, exe_cout,
        output rsp_valid, rsp_sum, rsp_cout, rsp_tag, err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, req_cmsk_n, req_tag,
        input  req_ready,
        input  exe_valid, exe_a, exe_b, exe_cin, exe_cmsk_n,
        output exe_rdy, exe_sum, exe_cout,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_tag, err,
        output rsp_ready
    );

endinterface
`default_nettype wire

// File: rtl/adder64_issue_ctrl_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync
//  Description : Synchronous FIFO with a registered head. The head register
//                always mirrors the oldest entry while non-empty, so data is
//                visible the edge after the first push; when the FIFO drains
//                the head keeps its last value.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] wdata,
    output logic      [WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
    localparam logic [c_AW-1:0] c_IDX_ONE = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [WIDTH-1:0] r_rd_data;
    logic [c_PW-1:0]  w_count;
    logic             w_push;
    logic             w_pop;
    logic [c_AW-1:0]  w_rd_nxt_idx;

    // Extra wrap bit distinguishes full from empty when indices match
    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign empty        = (r_wr_ptr == r_rd_ptr);
    assign full         = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                          (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push       = push & ~full;
    assign w_pop        = pop & ~empty;
    assign w_rd_nxt_idx = r_rd_ptr[c_AW-1:0] + c_IDX_ONE;
    assign rdata        = r_rd_data;

    // Storage array; entries are only observed after being written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
        end
    end

    // Pointer update and head register refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_pop && (w_count > c_PTR_ONE)) begin
                r_rd_data <= r_mem[w_rd_nxt_idx];
            end else if (w_push && (empty || (w_pop && (w_count == c_PTR_ONE)))) begin
                r_rd_data <= wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder64_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adder64_issue_ctrl
//  Description : Issue front-end for the fixed-latency SIMD adder. Credits
//                requests against the result buffer, re-attaches tags in
//                order and buffers results for backpressured writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder64_issue_ctrl
    import adder64_issue_ctrl_pkg::*;
#(
    parameter int LEN_DATA = c_LEN_DATA,
    parameter int LATENCY  = c_ADD_LATENCY,
    parameter int DEPTH    = c_DEPTH,
    parameter int TAG_W    = c_TAG_W
) (
    input  wire logic           clk,
    input  wire logic           rst,
    adder64_issue_ctrl_if.slave bus
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_RES_W = res_entry_width(TAG_W, LEN_DATA);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    // Every returning result must find a free slot, so the buffer must at
    // least cover the adder pipeline plus the head entry.
    if ((DEPTH < LATENCY + 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("adder64_issue_ctrl: DEPTH must be a power of two >= LATENCY+1");
    end

    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] w_out_next;
    logic               r_req_ready;
    logic               r_err;
    logic               w_accept;
    logic               w_rsp_pop;
    logic               w_tag_full;
    logic               w_tag_empty;
    logic [TAG_W-1:0]   w_tag_head;
    logic               w_res_push;
    logic               w_res_full;
    logic               w_res_empty;
    logic [c_RES_W-1:0] w_res_head;
    logic               w_err_evt;

    assign w_accept  = bus.req_valid & r_req_ready;
    assign w_rsp_pop = ~w_res_empty & bus.rsp_ready;
    // A result is only captured when a matching tag exists
    assign w_res_push = bus.exe_rdy & ~w_tag_empty;
    assign w_err_evt  = (bus.exe_rdy & w_tag_empty) |
                        (w_accept & w_tag_full) |
                        (w_res_push & w_res_full);

    // The adder registers its own inputs, so operands pass straight through
    assign bus.req_ready  = r_req_ready;
    assign bus.exe_valid  = w_accept;
    assign bus.exe_a      = bus.req_a;
    assign bus.exe_b      = bus.req_b;
    assign bus.exe_cin    = bus.req_cin;
    assign bus.exe_cmsk_n = bus.req_cmsk_n;

    assign bus.rsp_valid = ~w_res_empty;
    assign bus.rsp_tag   = w_res_head[c_RES_W-1 -: TAG_W];
    assign bus.rsp_sum   = w_res_head[LEN_DATA:1];
    assign bus.rsp_cout  = w_res_head[0];
    assign bus.err       = r_err;

    fifo_sync #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .pop   (bus.exe_rdy),
        .wdata (bus.req_tag),
        .rdata (w_tag_head),
        .full  (w_tag_full),
        .empty (w_tag_empty)
    );

    fifo_sync #(
        .WIDTH (c_RES_W),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_res_push),
        .pop   (w_rsp_pop),
        .wdata ({w_tag_head, bus.exe_sum, bus.exe_cout}),
        .rdata (w_res_head),
        .full  (w_res_full),
        .empty (w_res_empty)
    );

    // Next outstanding count: in-flight plus buffered results
    always_comb begin
        w_out_next = r_outstanding;
        if (w_accept && !w_rsp_pop) begin
            w_out_next = r_outstanding + c_CNT_ONE;
        end else if (!w_accept && w_rsp_pop) begin
            w_out_next = r_outstanding - c_CNT_ONE;
        end
    end

    // Credit counter, registered ready and sticky protocol error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_req_ready   <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            r_req_ready   <= (w_out_next < c_DEPTH_CNT);
            r_err         <= r_err | w_err_evt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder64_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder64_issue_ctrl
//  Description : Self-checking bench for adder64_issue_ctrl with a
//                behavioural fixed-latency adder and an in-order scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder64_issue_ctrl;
    import adder64_issue_ctrl_pkg::*;

    localparam int LD  = 64;
    localparam int TW  = 5;
    localparam int LAT = 9;
    localparam int DEP = 16;

    logic clk = 1'b0;
    logic rst;
    logic force_rdy = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    adder64_issue_ctrl_if #(.LEN_DATA(LD), .TAG_W(TW)) bus();

    adder64_issue_ctrl #(
        .LEN_DATA (LD),
        .LATENCY  (LAT),
        .DEPTH    (DEP),
        .TAG_W    (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte-lane add: carry into lane i comes from lane i-1 unless masked
    // (cmsk_n[i-1]=0), in which case that lane's own cin is used.
    function automatic logic [LD:0] ref_add(input logic [LD-1:0] a, input logic [LD-1:0] b,
                                            input logic [7:0] cin, input logic [7:0] cmsk_n);
        logic [LD-1:0] s;
        logic          c;
        logic [8:0]    t;
        s = '0;
        c = cin[0];
        for (int i = 0; i < 8; i++) begin
            if (i > 0 && !cmsk_n[i-1]) c = cin[i];
            t = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]} + {8'd0, c};
            s[8*i +: 8] = t[7:0];
            c = t[8];
        end
        return {c, s};
    endfunction

    // Behavioural adder64: LAT-stage pipeline, reset together with the block
    logic [LD:0] pipe_res [LAT];
    logic        pipe_v   [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                pipe_v[k]   <= 1'b0;
                pipe_res[k] <= '0;
            end
        end else begin
            pipe_v[0]   <= bus.exe_valid;
            pipe_res[0] <= ref_add(bus.exe_a, bus.exe_b, bus.exe_cin, bus.exe_cmsk_n);
            for (int k = 1; k < LAT; k++) begin
                pipe_v[k]   <= pipe_v[k-1];
                pipe_res[k] <= pipe_res[k-1];
            end
        end
    end
    assign bus.exe_rdy  = pipe_v[LAT-1] | force_rdy;
    assign bus.exe_sum  = pipe_res[LAT-1][LD-1:0];
    assign bus.exe_cout = pipe_res[LAT-1][LD];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected result queued at accept, compared at pop
    typedef struct {
        logic [TW-1:0] tag;
        logic [LD-1:0] sum;
        logic          cout;
    } exp_t;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [LD:0] mon_r;
    int          n_rsp = 0;
    int          first_rsp_cyc = -1;
    int          last_rsp_cyc = -1;
    logic        hold_prev = 1'b0;
    logic [LD+TW:0] hold_snap;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                mon_r = ref_add(bus.req_a, bus.req_b, bus.req_cin, bus.req_cmsk_n);
                exp_q.push_back('{bus.req_tag, mon_r[LD-1:0], mon_r[LD]});
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_rsp++;
                if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
                last_rsp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_tag", 64'(bus.rsp_tag), 64'(mon_e.tag));
                    chk("rsp_sum", bus.rsp_sum, mon_e.sum);
                    chk("rsp_cout", 64'(bus.rsp_cout), 64'(mon_e.cout));
                end
            end
            if (bus.rsp_valid && !bus.rsp_ready) begin
                if (hold_prev) begin
                    chk("rsp_hold", 64'(hold_snap[TW-1:0]), 64'(bus.rsp_tag));
                    chk("rsp_hold_sum", hold_snap[LD+TW:TW+1], bus.rsp_sum);
                end
                hold_snap = {bus.rsp_sum, bus.rsp_cout, bus.rsp_tag};
                hold_prev = 1'b1;
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    task automatic drive_rand(input logic [TW-1:0] tag);
        bus.req_a      = {$urandom(), $urandom()};
        bus.req_b      = {$urandom(), $urandom()};
        bus.req_cin    = 8'($urandom());
        bus.req_cmsk_n = 8'($urandom());
        bus.req_tag    = tag;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        logic [LD-1:0] a;
        logic [LD-1:0] b;
        logic [7:0]    cin;
        logic [7:0]    cmsk_n;
        logic [TW-1:0] tag;
        logic [LD-1:0] exp_sum;
        logic          exp_cout;
    } vec_t;
    vec_t vecs [5];

    initial begin
        int n;
        int drops;
        int accepts;
        int stale;
        logic [LD+TW:0] snap;

        vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 8'h00, 8'hFF, 5'd3,
                    64'h0000_0001_0000_0000, 1'b0};
        vecs[1] = '{64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 8'h00, 8'h00, 5'd7,
                    64'h0000_0000_0000_0000, 1'b0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 8'h00, 8'hFF, 5'd31,
                    64'h0, 1'b1};
        vecs[3] = '{64'h0, 64'h0, 8'hFF, 8'h00, 5'd0,
                    64'h0101_0101_0101_0101, 1'b0};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 8'h00, 8'hFF, 5'd18,
                    64'h1234_5678_9ABC_DF00, 1'b0};

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0;
        bus.req_cmsk_n = '0; bus.req_tag = '0; bus.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_rsp_sum", bus.rsp_sum, 64'd0);
        chk("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready_low", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        chk("rst_release_ready", 64'(bus.req_ready), 64'd1);

        // Table vectors, one request each into an empty block
        for (int v = 0; v < 5; v++) begin
            bus.req_a = vecs[v].a; bus.req_b = vecs[v].b; bus.req_cin = vecs[v].cin;
            bus.req_cmsk_n = vecs[v].cmsk_n; bus.req_tag = vecs[v].tag;
            bus.req_valid = 1'b1;
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            n = 1;
            while (!bus.rsp_valid && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
            chk("vec_latency", 64'(n), 64'(LAT + 1));
            chk("vec_sum", bus.rsp_sum, vecs[v].exp_sum);
            chk("vec_cout", 64'(bus.rsp_cout), 64'(vecs[v].exp_cout));
            chk("vec_tag", 64'(bus.rsp_tag), 64'(vecs[v].tag));
            @(posedge clk); #1;
            chk("vec_empty_valid", 64'(bus.rsp_valid), 64'd0);
            chk("vec_empty_hold", bus.rsp_sum, vecs[v].exp_sum);
        end

        // Back-to-back stream of 40
        n_rsp = 0; first_rsp_cyc = -1; last_rsp_cyc = -1; drops = 0;
        for (int i = 0; i < 40; i++) begin
            drive_rand(5'(i % 32));
            bus.req_valid = 1'b1;
            @(negedge clk);
            if (!bus.req_ready) drops++;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        chk("stream_ready_drops", 64'(drops), 64'd0);
        wait_drain("stream_drain", 60);
        chk("stream_rsp_count", 64'(n_rsp), 64'd40);
        chk("stream_back_to_back", 64'(last_rsp_cyc - first_rsp_cyc), 64'd39);

        // Backpressure until stall
        bus.rsp_ready = 1'b0;
        accepts = 0;
        for (int i = 0; i < 24; i++) begin
            drive_rand(5'(i));
            bus.req_valid = 1'b1;
            @(negedge clk);
            if (bus.req_ready) accepts++;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        chk("bp_accepts", 64'(accepts), 64'(DEP));
        chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        snap = {bus.rsp_sum, bus.rsp_cout, bus.rsp_tag};
        repeat (3) @(posedge clk);
        #1;
        chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("bp_stable_sum", bus.rsp_sum, snap[LD+TW:TW+1]);
        chk("bp_stable_tag", 64'(bus.rsp_tag), 64'(snap[TW-1:0]));
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_ready_not_comb", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp_ready_after_pop", 64'(bus.req_ready), 64'd1);
        wait_drain("bp_drain", 40);

        // Reset with 3 buffered and 5 in flight
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand(5'(i + 1)); bus.req_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            drive_rand(5'(i + 10)); bus.req_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #3;
        chk("pre_rst_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("async_rst_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) stale++;
        end
        chk("post_rst_stale", 64'(stale), 64'd0);
        chk("post_rst_err", 64'(bus.err), 64'd0);
        chk("post_rst_ready", 64'(bus.req_ready), 64'd1);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 150; i++) begin
            drive_rand(5'($urandom()));
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_drain("rand_drain", 60);
        chk("rand_err", 64'(bus.err), 64'd0);

        // Spurious exe_rdy with nothing outstanding
        force_rdy = 1'b1;
        @(posedge clk); #1;
        force_rdy = 1'b0;
        chk("spur_err_set", 64'(bus.err), 64'd1);
        chk("spur_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("spur_err_sticky", 64'(bus.err), 64'd1);
        chk("spur_rsp_valid_after", 64'(bus.rsp_valid), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("spur_err_cleared", 64'(bus.err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/adder64_issue_ctrl.md
Name: adder64_issue_ctrl

Overview:
- Initiator/front-end for the pipelined SIMD adder `adder64` (fixed latency, no backpressure, valid in / rdy out).
- Accepts tagged add requests over a valid/ready handshake and issues them to the adder.
- Tracks in-flight operations, re-attaches tags to results in order, and buffers results so downstream writeback can apply backpressure without losing data.
- Sits between ALU dispatch and register-file writeback.

Parameters:
- LEN_DATA, `LEN_DATA (64), operand/result width, taken from the shared define file.
- LATENCY, 9, adder cycles from valid sampled to rdy asserted.
- DEPTH, 16, result buffer entries; must be >= LATENCY+1, power of two.
- TAG_W, 5, request tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid & ready
- req_a  in  LEN_DATA  operand A
- req_b  in  LEN_DATA  operand B
- req_cin  in  8  per-lane carry-in
- req_cmsk_n  in  8  per-byte-lane carry mask, active-low
- req_tag  in  TAG_W  request tag
- exe_valid  out  1  to adder valid
- exe_a  out  LEN_DATA  to adder a
- exe_b  out  LEN_DATA  to adder b
- exe_cin  out  8  to adder cin
- exe_cmsk_n  out  8  to adder cmsk_n
- exe_rdy  in  1  from adder rdy
- exe_sum  in  LEN_DATA  from adder sum
- exe_cout  in  1  from adder cout
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accepts
- rsp_sum  out  LEN_DATA  result
- rsp_cout  out  1  carry-out
- rsp_tag  out  TAG_W  tag of the result
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, active-high) clears all state:
  - req_ready=0 while rst is high, 1 the cycle after deassert.
  - rsp_valid=0, err=0, counters/pointers=0, rsp_* data=0.
- Integration: adder en tied 1; adder rst_n = ~rst, so any in-flight adder work is discarded together with this block's state.
- Credit rule:
  - outstanding = in-flight (issued, exe_rdy not yet seen) + buffered results.
  - req_ready = (outstanding < DEPTH). This guarantees every returning result has a free buffer slot.
- Issue:
  - exe_valid = req_valid & req_ready.
  - exe_a/b/cin/cmsk_n = req_* combinationally; the adder registers its own inputs.
  - On accept, req_tag is pushed into the tag FIFO (depth DEPTH).
- Return:
  - On exe_rdy, pop the tag FIFO and write {tag, exe_sum, exe_cout} into the result FIFO at the same edge.
  - Ordering is strictly in order because adder latency is fixed.
- Output:
  - rsp_* driven from the result FIFO head, registered.
  - rsp_valid = result FIFO non-empty.
  - Pop on rsp_valid & rsp_ready.
  - rsp_* holds stable while rsp_valid & !rsp_ready.
- Outstanding counter (width clog2(DEPTH)+1):
  - +1 on accept, -1 on rsp pop, unchanged when both occur in the same cycle.
- Latency, empty block, rsp_ready=1:
  - exe_rdy is high in the cycle after the LATENCY-th edge, counting the accept edge as edge 1.
  - rsp_valid rises one edge later, i.e. LATENCY+1 edges after accept.
- Throughput: one request per cycle sustained while rsp_ready=1.
- Full: with outstanding=DEPTH, req_ready=0. A same-cycle rsp pop raises req_ready the next cycle, not combinationally.
- Empty: rsp_valid=0 and rsp_* holds its last value.
- Error (sticky until reset):
  - exe_rdy while the tag FIFO is empty sets err; no write occurs.
  - Tag/result FIFO overflow attempt sets err; no write occurs. This is unreachable if the credit rule is correct.
- Pointers wrap modulo DEPTH; full/empty use an extra wrap bit.

Decomposition:
- Shared package/define: LEN_DATA, ADD_LATENCY=9, ADD_LANES=8, result entry width TAG_W+LEN_DATA+1.
- One sub-module, `fifo_sync` (parameters WIDTH, DEPTH; push/pop/full/empty, registered read data, async active-high reset).
  - Instantiated twice: the tag FIFO and the result FIFO.
- Top level holds the credit counter, issue logic and error flag.

Test Plan:
- Reset then single request: a=0x0000_0000_FFFF_FFFF, b=1, cmsk_n=0xFF, cin=0, tag=3.
  - Expected: rsp_valid after 10 edges; rsp_sum=0x0000_0001_0000_0000, rsp_tag=3, cout=0.
- Byte-lane SIMD: a=0x00FF_00FF_00FF_00FF, b=0x0001_0001_0001_0001, cmsk_n=0x00.
  - Expected: rsp_sum=0x0000_0000_0000_0000, cout=0.
- Back-to-back stream of 40 requests, tags 0..31 wrapping, rsp_ready=1.
  - Expected: req_ready never drops; results in issue order with matching tags; one rsp per cycle after fill.
- Backpressure: rsp_ready=0, push until stall.
  - Expected: exactly 16 accepts, then req_ready=0; rsp_* stable.
  - Then rsp_ready=1: all 16 drain in order, and req_ready returns the cycle after the first pop.
- Reset mid-operation: rst pulsed with 5 in flight and 3 buffered.
  - Expected: rsp_valid=0 immediately (async); no stale result appears afterwards; err=0.
- Spurious exe_rdy forced with no outstanding request.
  - Expected: err=1 next cycle and stays 1; rsp_valid stays 0; err clears only on reset.
